// File: rtl/obi_wishbone_bridge_if.sv
// Signal bundle between the core's two OBI ports, the bridge and the Wishbone core bus.
// Names keep the bridge's point of view: *_i flows into the bridge, *_o flows out of it.
interface obi_wishbone_bridge_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  logic        core_cyc_o;
  logic        core_stb_o;
  logic        core_we_o;
  logic [31:0] core_addr_o;
  logic [31:0] core_data_o;
  logic [31:0] core_data_i;
  logic        core_ack_i;

  // Bridge side: OBI slave towards the core, Wishbone master towards the bus.
  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  core_data_i, core_ack_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output core_cyc_o, core_stb_o, core_we_o, core_addr_o, core_data_o
  );

  // Environment side: core ports plus the bus responder.
  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output core_data_i, core_ack_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  core_cyc_o, core_stb_o, core_we_o, core_addr_o, core_data_o
  );
endinterface

// File: rtl/obi_wishbone_bridge.sv
// Arbitrates the core's instruction and data OBI ports onto one Wishbone-classic bus, one
// transaction at a time; partial-word stores become a read-modify-write.
module obi_wishbone_bridge #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input logic               clk_core,
  input logic               rst_core,
  obi_wishbone_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StRead, StWrite, StRmwRd, StRmwGap, StRmwWr, StResp
  } state_e;

  state_e      r_state;
  logic        r_src_data;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_core_data;
  logic        r_instr_rvalid;
  logic        r_data_rvalid;
  logic [31:0] r_instr_rdata;
  logic [31:0] r_data_rdata;

  logic        w_idle;
  logic        w_sel_data;
  logic        w_sel_instr;
  logic        w_data_gnt;
  logic        w_instr_gnt;
  logic        w_store;
  logic        w_full;
  logic [31:0] w_addr;
  logic [31:0] w_merged;

  assign w_idle      = (r_state == StIdle);
  assign w_sel_data  = bus.data_req_i & (DATA_PRIORITY | ~bus.instr_req_i);
  assign w_sel_instr = bus.instr_req_i & (~DATA_PRIORITY | ~bus.data_req_i);
  assign w_data_gnt  = w_idle & w_sel_data;
  assign w_instr_gnt = w_idle & w_sel_instr;
  assign w_store     = w_data_gnt & bus.data_we_i;
  assign w_full      = (bus.data_be_i == 4'hF);
  assign w_addr      = w_data_gnt ? {bus.data_addr_i[31:2], 2'b00}
                                  : {bus.instr_addr_i[31:2], 2'b00};

  // Enabled bytes come from the store, the rest from the word just read back.
  always_comb begin
    w_merged = bus.core_data_i;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_state        <= StIdle;
      r_src_data     <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_cyc          <= 1'b0;
      r_stb          <= 1'b0;
      r_we           <= 1'b0;
      r_core_data    <= '0;
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_instr_rdata  <= '0;
      r_data_rdata   <= '0;
    end else begin
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_data_gnt || w_instr_gnt) begin
            r_src_data <= w_data_gnt;
            r_addr     <= w_addr;
            r_be       <= bus.data_be_i;
            r_wdata    <= bus.data_wdata_i;
            if (w_store && (bus.data_be_i == 4'h0)) begin
              // Nothing to write: answer without touching the bus.
              r_data_rvalid <= 1'b1;
              r_state       <= StResp;
            end else begin
              r_cyc       <= 1'b1;
              r_stb       <= 1'b1;
              r_we        <= w_store & w_full;
              r_core_data <= (w_store && w_full) ? bus.data_wdata_i : 32'h0;
              r_state     <= !w_store ? StRead : (w_full ? StWrite : StRmwRd);
            end
          end
        end
        StRead: begin
          if (bus.core_ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_src_data) begin
              r_data_rdata  <= bus.core_data_i;
              r_data_rvalid <= 1'b1;
            end else begin
              r_instr_rdata  <= bus.core_data_i;
              r_instr_rvalid <= 1'b1;
            end
            r_state <= StResp;
          end
        end
        StRmwRd: begin
          if (bus.core_ack_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_wdata <= w_merged;
            r_state <= StRmwGap;
          end
        end
        StRmwGap: begin
          r_cyc       <= 1'b1;
          r_stb       <= 1'b1;
          r_we        <= 1'b1;
          r_core_data <= r_wdata;
          r_state     <= StRmwWr;
        end
        StWrite, StRmwWr: begin
          if (bus.core_ack_i) begin
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_data_rvalid <= 1'b1;
            r_state       <= StResp;
          end
        end
        StResp: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.instr_gnt_o    = w_instr_gnt;
  assign bus.data_gnt_o     = w_data_gnt;
  assign bus.instr_rvalid_o = r_instr_rvalid;
  assign bus.instr_rdata_o  = r_instr_rdata;
  assign bus.data_rvalid_o  = r_data_rvalid;
  assign bus.data_rdata_o   = r_data_rdata;
  assign bus.core_cyc_o     = r_cyc;
  assign bus.core_stb_o     = r_stb;
  assign bus.core_we_o      = r_we;
  assign bus.core_addr_o    = r_addr;
  assign bus.core_data_o    = r_core_data;

endmodule

// File: tb/tb_obi_wishbone_bridge.sv
// Directed bench for obi_wishbone_bridge: scoreboarded bus phases and responses, a memory-backed
// Wishbone responder, and two instances to cover both arbitration priorities.
module tb_obi_wishbone_bridge;

  logic clk_core = 1'b0;
  logic rst_core = 1'b1;
  always #5 clk_core = ~clk_core;

  logic        sel = 1'b0;  // 0: DATA_PRIORITY=1 instance, 1: DATA_PRIORITY=0 instance
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] core_rdata = '0;
  logic        core_ack = 1'b0;

  obi_wishbone_bridge_if bif_p1 ();
  obi_wishbone_bridge_if bif_p0 ();

  obi_wishbone_bridge #(.DATA_PRIORITY(1'b1)) u_dut_p1 (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .bus      (bif_p1)
  );
  obi_wishbone_bridge #(.DATA_PRIORITY(1'b0)) u_dut_p0 (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .bus      (bif_p0)
  );

  assign bif_p1.instr_req_i  = instr_req & ~sel;
  assign bif_p0.instr_req_i  = instr_req & sel;
  assign bif_p1.data_req_i   = data_req & ~sel;
  assign bif_p0.data_req_i   = data_req & sel;
  assign bif_p1.core_ack_i   = core_ack & ~sel;
  assign bif_p0.core_ack_i   = core_ack & sel;
  assign bif_p1.instr_addr_i = instr_addr;
  assign bif_p0.instr_addr_i = instr_addr;
  assign bif_p1.data_we_i    = data_we;
  assign bif_p0.data_we_i    = data_we;
  assign bif_p1.data_be_i    = data_be;
  assign bif_p0.data_be_i    = data_be;
  assign bif_p1.data_addr_i  = data_addr;
  assign bif_p0.data_addr_i  = data_addr;
  assign bif_p1.data_wdata_i = data_wdata;
  assign bif_p0.data_wdata_i = data_wdata;
  assign bif_p1.core_data_i  = core_rdata;
  assign bif_p0.core_data_i  = core_rdata;

  logic        v_instr_gnt, v_instr_rvalid, v_data_gnt, v_data_rvalid;
  logic        v_cyc, v_stb, v_we;
  logic [31:0] v_instr_rdata, v_data_rdata, v_addr, v_wdata;
  assign v_instr_gnt    = sel ? bif_p0.instr_gnt_o    : bif_p1.instr_gnt_o;
  assign v_instr_rvalid = sel ? bif_p0.instr_rvalid_o : bif_p1.instr_rvalid_o;
  assign v_instr_rdata  = sel ? bif_p0.instr_rdata_o  : bif_p1.instr_rdata_o;
  assign v_data_gnt     = sel ? bif_p0.data_gnt_o     : bif_p1.data_gnt_o;
  assign v_data_rvalid  = sel ? bif_p0.data_rvalid_o  : bif_p1.data_rvalid_o;
  assign v_data_rdata   = sel ? bif_p0.data_rdata_o   : bif_p1.data_rdata_o;
  assign v_cyc          = sel ? bif_p0.core_cyc_o     : bif_p1.core_cyc_o;
  assign v_stb          = sel ? bif_p0.core_stb_o     : bif_p1.core_stb_o;
  assign v_we           = sel ? bif_p0.core_we_o      : bif_p1.core_we_o;
  assign v_addr         = sel ? bif_p0.core_addr_o    : bif_p1.core_addr_o;
  assign v_wdata        = sel ? bif_p0.core_data_o    : bif_p1.core_data_o;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} bus_t;
  typedef struct packed {logic is_data; logic [31:0] rdata;} rsp_t;

  bus_t        exp_bus[$];
  rsp_t        exp_rsp[$];
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int waits = 0;
  int last_ack = -1;
  int last_rise = -1;
  int last_rv = -1;
  int stb_cnt = 0;
  int cyc_cycles = 0;
  int rv_cnt = 0;

  always @(posedge clk_core) cnt <= cnt + 1;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Wishbone responder: acks after `waits` stb cycles, backed by mem.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk_core);
      if (core_ack) begin
        core_ack = 1'b0;
        wcnt     = 0;
      end else if (v_cyc && v_stb && !rst_core) begin
        if (wcnt == waits) begin
          core_ack = 1'b1;
          last_ack = cnt;
          if (v_we) mem[v_addr] = v_wdata;
          else      core_rdata  = mem_rd(v_addr);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new stb interval and each rvalid.
  initial begin : monitor
    bus_t cur, e;
    rsp_t r;
    logic prev_stb;
    prev_stb = 1'b0;
    cur      = '0;
    forever begin
      @(negedge clk_core);
      if (rst_core) begin
        prev_stb = 1'b0;
        continue;
      end
      if (v_cyc) cyc_cycles++;
      if (v_stb && !prev_stb) begin
        stb_cnt++;
        last_rise = cnt;
        check("bus_expected", exp_bus.size() != 0, 1'b1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          check("bus_addr", v_addr, e.addr);
          check("bus_we", v_we, e.we);
          check("bus_data", v_wdata, e.data);
          check("bus_cyc", v_cyc, 1'b1);
        end
        cur = '{we: v_we, addr: v_addr, data: v_wdata};
      end else if (v_stb) begin
        check("bus_stable", {v_we, v_addr, v_wdata}, cur);
      end
      prev_stb = v_stb;
      if (v_instr_rvalid || v_data_rvalid) begin
        rv_cnt++;
        last_rv = cnt;
        check("rsp_expected", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          check("rsp_src", {v_instr_rvalid, v_data_rvalid}, {~r.is_data, r.is_data});
          check("rsp_rdata", r.is_data ? v_data_rdata : v_instr_rdata, r.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_bus.push_back('{we: we, addr: addr, data: data});
  endtask

  task automatic push_rsp(input logic is_data, input logic [31:0] rdata);
    exp_rsp.push_back('{is_data: is_data, rdata: rdata});
  endtask

  task automatic issue(input logic is_data, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, output int gcyc);
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
    end else begin
      instr_req = 1'b1; instr_addr = addr;
    end
    gcyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_core);
      if (is_data ? v_data_gnt : v_instr_gnt) begin
        gcyc = cnt;
        break;
      end
    end
    check("grant_seen", gcyc >= 0, 1'b1);
    @(posedge clk_core);
    #1;
    instr_req = 1'b0;
    data_req  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_rsp.size() != 0) && n < 100) begin
      @(negedge clk_core);
      n++;
    end
    check(tag, exp_bus.size() + exp_rsp.size(), 0);
    exp_bus.delete();
    exp_rsp.delete();
    tick();
  endtask

  // Both ports request in the same idle cycle; the loser must wait for the winner's response.
  task automatic dual(input logic data_first);
    int gl;
    gl = -1;
    instr_req = 1'b1; instr_addr = 32'h300;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h200;
    @(negedge clk_core);
    check("dual_win_gnt", data_first ? v_data_gnt : v_instr_gnt, 1'b1);
    check("dual_lose_gnt", data_first ? v_instr_gnt : v_data_gnt, 1'b0);
    @(posedge clk_core);
    #1;
    if (data_first) data_req = 1'b0;
    else            instr_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_core);
      if (data_first ? v_instr_gnt : v_data_gnt) begin
        gl = cnt;
        break;
      end
    end
    check("dual_lose_lat", gl, last_ack + 2);
    @(posedge clk_core);
    #1;
    instr_req = 1'b0;
    data_req  = 1'b0;
    wait_idle("dual_drain");
  endtask

  initial begin : main
    int g, s0, c0, rv0;
    logic found;

    // Reset values
    tick();
    tick();
    check("rst_ctrl", {v_cyc, v_stb, v_we, v_instr_rvalid, v_data_rvalid}, 5'h0);
    check("rst_addr", v_addr, 32'h0);
    check("rst_wdata", v_wdata, 32'h0);
    check("rst_rdata", {v_instr_rdata, v_data_rdata}, 64'h0);
    rst_core = 1'b0;
    tick();

    // Instruction fetch, two wait states
    mem[32'h104] = 32'h0051_3023;
    waits = 2;
    push_bus(1'b0, 32'h104, 32'h0);
    push_rsp(1'b0, 32'h0051_3023);
    issue(1'b0, 1'b0, 4'h0, 32'h104, 32'h0, g);
    wait_idle("fetch_drain");
    check("fetch_stb_lat", last_rise, g + 1);
    check("fetch_ack_cyc", last_ack, g + 3);
    check("fetch_rv_lat", last_rv, last_ack + 1);

    // Full-word store: data_rdata keeps its reset value
    waits = 1;
    s0 = stb_cnt;
    push_bus(1'b1, 32'h80, 32'hDEAD_BEEF);
    push_rsp(1'b1, 32'h0);
    issue(1'b1, 1'b1, 4'hF, 32'h80, 32'hDEAD_BEEF, g);
    wait_idle("store_drain");
    check("store_mem", mem_rd(32'h80), 32'hDEAD_BEEF);
    check("store_stb_n", stb_cnt - s0, 1);
    check("store_rv_lat", last_rv, last_ack + 1);

    // Load from an unaligned address, zero wait states
    mem[32'h200] = 32'hCAFE_0001;
    waits = 0;
    push_bus(1'b0, 32'h200, 32'h0);
    push_rsp(1'b1, 32'hCAFE_0001);
    issue(1'b1, 1'b0, 4'hF, 32'h203, 32'h0, g);
    wait_idle("load_drain");
    check("load_rv_lat", last_rv, g + 2);

    // Partial store via read-modify-write
    mem[32'h84] = 32'h1122_3344;
    s0 = stb_cnt;
    push_bus(1'b0, 32'h84, 32'h0);
    push_bus(1'b1, 32'h84, 32'h1122_AA44);
    push_rsp(1'b1, 32'hCAFE_0001);
    issue(1'b1, 1'b1, 4'b0010, 32'h84, 32'h0000_AA00, g);
    wait_idle("rmw_drain");
    check("rmw_stb_n", stb_cnt - s0, 2);
    check("rmw_wr_rise", last_rise, g + 3);
    check("rmw_rv_lat", last_rv, g + 4);
    check("rmw_mem", mem_rd(32'h84), 32'h1122_AA44);
    check("instr_rdata_kept", v_instr_rdata, 32'h0051_3023);

    // Zero-byte store: no bus activity at all
    s0 = stb_cnt;
    c0 = cyc_cycles;
    push_rsp(1'b1, 32'hCAFE_0001);
    issue(1'b1, 1'b1, 4'h0, 32'h88, 32'h1234_5678, g);
    wait_idle("be0_drain");
    check("be0_no_stb", stb_cnt - s0, 0);
    check("be0_no_cyc", cyc_cycles - c0, 0);
    check("be0_rv_lat", last_rv, g + 1);

    // Simultaneous requests, data priority
    mem[32'h300] = 32'h0000_0013;
    push_bus(1'b0, 32'h200, 32'h0);
    push_bus(1'b0, 32'h300, 32'h0);
    push_rsp(1'b1, 32'hCAFE_0001);
    push_rsp(1'b0, 32'h0000_0013);
    dual(1'b1);

    // Same with instruction priority
    sel = 1'b1;
    tick();
    push_bus(1'b0, 32'h300, 32'h0);
    push_bus(1'b0, 32'h200, 32'h0);
    push_rsp(1'b0, 32'h0000_0013);
    push_rsp(1'b1, 32'hCAFE_0001);
    dual(1'b0);
    sel = 1'b0;
    tick();

    // Reset while the RMW write strobe is up
    mem[32'h90] = 32'hA5A5_A5A5;
    waits = 3;
    push_bus(1'b0, 32'h90, 32'h0);
    push_bus(1'b1, 32'h90, 32'h5AA5_A5A5);
    issue(1'b1, 1'b1, 4'b1000, 32'h90, 32'h5A00_0000, g);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_core);
      if (v_stb && v_we) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_wr_seen", found, 1'b1);
    #1;
    rv0 = rv_cnt;
    rst_core = 1'b1;
    #1;
    check("rst_mid_ctrl", {v_cyc, v_stb, v_we, v_instr_rvalid, v_data_rvalid}, 5'h0);
    check("rst_mid_addr", {v_addr, v_wdata}, 64'h0);
    check("rst_mid_rdata", {v_instr_rdata, v_data_rdata}, 64'h0);
    tick();
    tick();
    exp_bus.delete();
    exp_rsp.delete();
    rst_core = 1'b0;
    tick();
    tick();
    check("rst_no_rvalid", rv_cnt, rv0);
    check("rst_no_write", mem_rd(32'h90), 32'hA5A5_A5A5);

    // Fresh fetch after reset
    waits = 0;
    push_bus(1'b0, 32'h104, 32'h0);
    push_rsp(1'b0, 32'h0051_3023);
    issue(1'b0, 1'b0, 4'h0, 32'h104, 32'h0, g);
    wait_idle("post_rst_drain");
    check("post_rst_rv", rv_cnt, rv0 + 1);
    check("post_rst_lat", last_rv, g + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
